pc_sequencer: RTL and testbench

//   Program-counter stage directly upstream of the R-format datapath: holds the PC that drives
//   the instruction-memory address (AddrIn) and captures the incremented address (AddrOut) back.

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Run-control and PC bus between the sequencer and its environment.
// master drives controls and next_pc; slave returns pc, status and count.
interface pc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             stall;
  logic             step_mode;
  logic             step;
  logic [31:0]      next_pc;
  logic [31:0]      pc;
  logic             commit;
  logic             running;
  logic             halted;
  logic             misalign;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, abort, stall,
    output step_mode, step, next_pc,
    input  pc, commit, running,
    input  halted, misalign, instr_count
  );

  modport slave (
    input  start, abort, stall,
    input  step_mode, step, next_pc,
    output pc, commit, running,
    output halted, misalign, instr_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC stage with start/abort, stall, single-step and halt detection.
// Ports: clk, rst (async high), bus (pc_sequencer_if.slave).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] END_PC    = 32'h0000_0100,
  parameter int          MAX_INSTR = 0,
  parameter int          CNT_W     = 16
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           st_q;
  state_t           st_d;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             mis_q;
  logic             commit;
  logic             clr;
  logic             mis_np;
  logic             max_hit;
  logic             halt;

  assign commit = (st_q == RUN) & ~bus.stall
                & (~bus.step_mode | bus.step)
                & ~bus.abort;

  // Saturate rather than wrap.
  assign cnt_inc = (&cnt_q) ? cnt_q
                 : cnt_q + 1'b1;

  assign mis_np  = |bus.next_pc[1:0];
  assign max_hit = (MAX_INSTR != 0) &&
                   (cnt_inc == CNT_W'(MAX_INSTR));
  assign halt    = commit &
                   ((bus.next_pc == END_PC) |
                    max_hit | mis_np);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // clr reloads the run context: PC, counter
  // and the sticky misalign flag.
  always_comb begin
    st_d = st_q;
    clr  = 1'b0;
    if (bus.abort) begin
      st_d = IDLE;
      clr  = 1'b1;
    end else begin
      case (st_q)
        IDLE: begin
          clr = 1'b1;
          if (bus.start) st_d = RUN;
        end
        RUN: begin
          if (halt) st_d = DONE;
        end
        DONE: begin
          if (bus.start) begin
            st_d = RUN;
            clr  = 1'b1;
          end
        end
        default: begin
          st_d = IDLE;
          clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else if (clr) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else if (commit) begin
      // Misaligned target still loads for debug.
      pc_q  <= bus.next_pc;
      cnt_q <= cnt_inc;
      if (mis_np) mis_q <= 1'b1;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.commit      = commit;
  assign bus.running     = (st_q == RUN);
  assign bus.halted      = (st_q == DONE);
  assign bus.misalign    = mis_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three instances checked per cycle
// against a behavioural model, directed steps then random.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, stall, step_mode, step;
  logic [31:0] np [3];

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_W(16)) ia ();
  pc_sequencer_if #(.CNT_W(16)) ib ();
  pc_sequencer_if #(.CNT_W(3))  ic ();

  pc_sequencer #(
    .RESET_PC(32'h0), .END_PC(32'h10),
    .MAX_INSTR(0), .CNT_W(16)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia));

  pc_sequencer #(
    .RESET_PC(32'h0), .END_PC(32'hFFFF_FF00),
    .MAX_INSTR(3), .CNT_W(16)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib));

  pc_sequencer #(
    .RESET_PC(32'h0), .END_PC(32'hFFFF_FF00),
    .MAX_INSTR(0), .CNT_W(3)
  ) dut_c (.clk(clk), .rst(rst), .bus(ic));

  assign ia.start = start;     assign ib.start = start;
  assign ic.start = start;
  assign ia.abort = abort;     assign ib.abort = abort;
  assign ic.abort = abort;
  assign ia.stall = stall;     assign ib.stall = stall;
  assign ic.stall = stall;
  assign ia.step_mode = step_mode;
  assign ib.step_mode = step_mode;
  assign ic.step_mode = step_mode;
  assign ia.step = step;       assign ib.step = step;
  assign ic.step = step;
  assign ia.next_pc = np[0];   assign ib.next_pc = np[1];
  assign ic.next_pc = np[2];

  logic [31:0] o_pc  [3];
  logic [15:0] o_cnt [3];
  logic        o_com [3];
  logic        o_run [3];
  logic        o_hlt [3];
  logic        o_mis [3];

  assign o_pc[0] = ia.pc;  assign o_pc[1] = ib.pc;
  assign o_pc[2] = ic.pc;
  assign o_cnt[0] = ia.instr_count;
  assign o_cnt[1] = ib.instr_count;
  assign o_cnt[2] = {13'b0, ic.instr_count};
  assign o_com[0] = ia.commit;  assign o_com[1] = ib.commit;
  assign o_com[2] = ic.commit;
  assign o_run[0] = ia.running; assign o_run[1] = ib.running;
  assign o_run[2] = ic.running;
  assign o_hlt[0] = ia.halted;  assign o_hlt[1] = ib.halted;
  assign o_hlt[2] = ic.halted;
  assign o_mis[0] = ia.misalign;
  assign o_mis[1] = ib.misalign;
  assign o_mis[2] = ic.misalign;

  // Per-instance parameters seen by the model.
  logic [31:0] endpc [3] = '{32'h10, 32'hFFFF_FF00, 32'hFFFF_FF00};
  int          maxi  [3] = '{0, 3, 0};
  int          cmax  [3] = '{65535, 65535, 7};

  // Model: run/done flags, pc, count, misalign.
  bit          m_run [3];
  bit          m_done[3];
  logic [31:0] m_pc  [3];
  int          m_cnt [3];
  bit          m_mis [3];
  int          n_com [3];

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int d,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h",
             tag, d, obs, exp);
    end
  endtask

  task automatic mclr(input int i);
    m_pc[i]  = 32'h0;
    m_cnt[i] = 0;
    m_mis[i] = 1'b0;
  endtask

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      m_run[i]  = 1'b0;
      m_done[i] = 1'b0;
      mclr(i);
    end
  endtask

  task automatic clr_com();
    for (int i = 0; i < 3; i++) n_com[i] = 0;
  endtask

  // One clock: drive next_pc, check at negedge, advance model.
  task automatic tick(input bit ov = 1'b0,
                      input int ovd = 0,
                      input logic [31:0] ovv = 32'h0);
    bit ec;
    bit hlt;
    for (int i = 0; i < 3; i++) np[i] = m_pc[i] + 32'd4;
    if (ov) np[ovd] = ovv;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ec = m_run[i] && !stall && (!step_mode || step) && !abort;
      chk("commit",   i, 32'(o_com[i]), 32'(ec));
      chk("pc",       i, o_pc[i],       m_pc[i]);
      chk("running",  i, 32'(o_run[i]), 32'(m_run[i]));
      chk("halted",   i, 32'(o_hlt[i]), 32'(m_done[i]));
      chk("misalign", i, 32'(o_mis[i]), 32'(m_mis[i]));
      chk("count",    i, 32'(o_cnt[i]), 32'(m_cnt[i]));
      if (ec) n_com[i]++;
      if (abort) begin
        m_run[i] = 1'b0; m_done[i] = 1'b0; mclr(i);
      end else if (!m_run[i] && !m_done[i]) begin
        mclr(i);
        if (start) m_run[i] = 1'b1;
      end else if (m_done[i]) begin
        if (start) begin
          mclr(i); m_done[i] = 1'b0; m_run[i] = 1'b1;
        end
      end else if (ec) begin
        m_pc[i]  = np[i];
        m_cnt[i] = (m_cnt[i] >= cmax[i]) ? cmax[i] : m_cnt[i] + 1;
        hlt = (np[i] == endpc[i]) ||
              (maxi[i] != 0 && m_cnt[i] == maxi[i]) ||
              (np[i][1:0] != 2'b00);
        if (np[i][1:0] != 2'b00) m_mis[i] = 1'b1;
        if (hlt) begin m_run[i] = 1'b0; m_done[i] = 1'b1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 0; abort = 0; stall = 0; step_mode = 0; step = 0;
    for (int i = 0; i < 3; i++) np[i] = 32'h0;
    mreset();
    clr_com();
    @(posedge clk); @(posedge clk); #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pc",  i, o_pc[i],        32'h0);
      chk("rst_cnt", i, 32'(o_cnt[i]),  32'h0);
      chk("rst_run", i, 32'(o_run[i]),  32'h0);
      chk("rst_hlt", i, 32'(o_hlt[i]),  32'h0);
      chk("rst_com", i, 32'(o_com[i]),  32'h0);
      chk("rst_mis", i, 32'(o_mis[i]),  32'h0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Run to END_PC on instance A; B stops on MAX_INSTR.
    clr_com();
    start = 1; tick(); start = 0;
    repeat (6) tick();
    chk("t1_pc",     0, o_pc[0],        32'h10);
    chk("t1_halt",   0, 32'(o_hlt[0]),  32'h1);
    chk("t1_cnt",    0, 32'(o_cnt[0]),  32'd4);
    chk("t1_commits",0, 32'(n_com[0]),  32'd4);
    chk("t5_cnt",    1, 32'(o_cnt[1]),  32'd3);
    chk("t5_halt",   1, 32'(o_hlt[1]),  32'h1);
    chk("t5_pc",     1, o_pc[1],        32'hC);

    // Stall three cycles at pc=8.
    start = 1; tick(); start = 0;
    tick(); tick();
    chk("t2_pc8", 0, o_pc[0], 32'h8);
    stall = 1; repeat (3) tick(); stall = 0;
    chk("t2_hold_pc",  0, o_pc[0],       32'h8);
    chk("t2_hold_cnt", 0, 32'(o_cnt[0]), 32'd2);
    tick();
    chk("t2_resume", 0, o_pc[0], 32'hC);
    abort = 1; tick(); abort = 0;

    // Single-step: pulses on cycles 2 and 7 only.
    step_mode = 1;
    start = 1; tick(); start = 0;
    clr_com();
    for (int c = 0; c < 8; c++) begin
      step = (c == 2 || c == 7);
      tick();
    end
    step = 0;
    chk("t3_commits", 0, 32'(n_com[0]),  32'd2);
    chk("t3_pc",      0, o_pc[0],        32'h8);
    chk("t3_running", 0, 32'(o_run[0]),  32'h1);
    step_mode = 0;

    // Misaligned target from pc=4.
    abort = 1; tick(); abort = 0;
    start = 1; tick(); start = 0;
    tick();
    tick(1'b1, 0, 32'h6);
    chk("t4_pc",   0, o_pc[0],       32'h6);
    chk("t4_halt", 0, 32'(o_hlt[0]), 32'h1);
    chk("t4_mis",  0, 32'(o_mis[0]), 32'h1);
    start = 1; tick(); start = 0;
    chk("t4_mis_clr", 0, 32'(o_mis[0]), 32'h0);
    chk("t4_pc_clr",  0, o_pc[0],       32'h0);

    // Counter saturation on the 3-bit instance.
    abort = 1; tick(); abort = 0;
    start = 1; tick(); start = 0;
    repeat (10) tick();
    chk("sat_cnt", 2, 32'(o_cnt[2]), 32'd7);
    chk("sat_run", 2, 32'(o_run[2]), 32'h1);
    chk("sat_pc",  2, o_pc[2],       32'h28);

    // Asynchronous reset off-edge, mid-run.
    abort = 1; tick(); abort = 0;
    start = 1; tick(); start = 0;
    tick(); tick();
    @(negedge clk); #2 rst = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_pc",  i, o_pc[i],       32'h0);
      chk("arst_run", i, 32'(o_run[i]), 32'h0);
      chk("arst_cnt", i, 32'(o_cnt[i]), 32'h0);
    end
    mreset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // abort together with start: IDLE wins.
    start = 1; tick(); start = 0;
    tick();
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    chk("ab_st_run", 2, 32'(o_run[2]), 32'h0);
    chk("ab_st_pc",  2, o_pc[2],       32'h0);

    // Random run against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      start = ($urandom % 8) == 0;
      abort = ($urandom % 50) == 0;
      stall = ($urandom % 4) == 0;
      if (($urandom % 16) == 0) step_mode = ~step_mode;
      step  = ($urandom % 3) == 0;
      r = $urandom % 16;
      if (r == 0)
        tick(1'b1, int'($urandom % 3),
             m_pc[$urandom % 3] + ($urandom % 8));
      else if (r == 1)
        tick(1'b1, 0, 32'h10);
      else
        tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
